bsg_manycore_mesh_router: RTL and testbench
===========================================

Name: bsg_manycore_mesh_router

Overview:
- Five-port (P,W,E,N,S) dimension-ordered mesh router with per-input FIFO buffering and per-output round-robin arbitration.
- Used as the switch inside each array tile, one instance per network.
- Generalises the tile-level routing: parameterised coordinate and payload widths, FIFO depth, per-port stubbing, and selectable XY/YX order so the same block serves both the request network (XY) and the return network (YX).

Parameters:
- x_cord_width_p, 2, destination/local X coordinate width.
- y_cord_width_p, 2, destination/local Y coordinate width.
- data_width_p, 32, payload bits above the coordinate field.
- fifo_els_p, 2, entries per input FIFO; must be >=2.
- stub_p, 5'b0, per-port stub mask indexed {S,N,E,W,P}.
- yx_order_p, 0, 0 = route X first, 1 = route Y first.
- packet_width_lp, data_width_p+x_cord_width_p+y_cord_width_p, derived flit width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-low reset (0 = reset).
- data_i  in  [S:P][packet_width_lp]  input flits, {payload, y_cord, x_cord}; x_cord is in the LSBs.
- v_i  in  [S:P]  input valid.
- ready_o  out  [S:P]  input FIFO not full.
- data_o  out  [S:P][packet_width_lp]  output flits.
- v_o  out  [S:P]  output valid.
- ready_i  in  [S:P]  downstream ready.
- my_x_i  in  x_cord_width_p  tile X.
- my_y_i  in  y_cord_width_p  tile Y.

Behaviour:
Reset and input side:
- While reset_i==0 at a clock edge: all FIFOs empty, all arbiter pointers = P (index 0).
- During reset: v_o=0, ready_o=0.
- First cycle after reset: ready_o=1 on every non-stubbed port.
- Input enqueue occurs when v_i & ready_o at the clock edge. ready_o depends only on FIFO occupancy, never on v_i.
- A full FIFO holds ready_o=0. Dequeue and enqueue in the same cycle on a full FIFO is not permitted, because ready_o is already low.

Routing (decoded on the FIFO head):
- Let dx = head x_cord, dy = head y_cord.
- XY mode:
  - dx<my_x -> W; dx>my_x -> E.
  - Otherwise dy<my_y -> N; dy>my_y -> S.
  - Otherwise -> P.
- YX mode: same comparisons with Y resolved before X.
- Comparisons are unsigned. P->P loopback is legal.

Arbitration:
- Each output has an independent round-robin arbiter over inputs requesting it.
- Priority starts at the pointer and increments with wrap S->P.
- v_o[o] = any request to o.
- data_o[o] = the granted head, unmodified.
- Transfer occurs when v_o & ready_i. On transfer, the granted head dequeues and the pointer for o moves to grantee+1 (mod 5).
- With no transfer, the pointer holds and the grant stays stable: a valid output keeps the same flit until accepted.
- Different outputs transfer in the same cycle independently, up to 5 flits per cycle.

Latency and throughput:
- Minimum latency is 1 cycle: a flit enqueued at edge t can be on data_o during cycle t+1.
- Sustained one flit per cycle per input when uncontended and ready_i=1.

Stubbed ports (stub_p bit set):
- ready_o=1 and v_i is ignored (never enqueued).
- v_o=0, data_o=0.
- A flit routed toward a stubbed output is dequeued and dropped on its arbitration grant, asserting nothing, so the input never deadlocks.

Reset mid-operation:
- Any in-flight FIFO contents are discarded.
- Outputs deassert in the same cycle reset_i is sampled low.

Test Plan:
- Reset: hold reset_i=0 for 3 cycles with v_i=5'b11111 -> v_o=0 and ready_o=0 throughout; the cycle after release, ready_o=5'b11111 and v_o=0.
- XY routing at my_x=1, my_y=1, yx_order_p=0: inject on P flits with (x,y)=(0,2),(2,0),(1,0),(1,2),(1,1) -> each emerges one cycle later on W,E,N,S,P respectively, with payload intact.
- YX mode, yx_order_p=1: P flit to (2,0) -> exits N, not E.
- Contention: W,E,N simultaneously send to dest (1,1) with payloads 0xA,0xB,0xC and ready_i[P]=1 -> P outputs 0xA,0xB,0xC on consecutive cycles. A second identical burst outputs in order E?N?W following the pointer: 0xA then pointer at E, so 0xB,0xC,0xA.
- Backpressure: ready_i[E]=0 for 6 cycles while P streams to E with fifo_els_p=2 -> v_o[E]=1 with data_o stable; ready_o[P] drops to 0 after 2 accepted flits. When ready_i[E] returns to 1, all flits drain in order with no loss or duplication.
- Stub: stub_p=5'b00100 (E stubbed) -> ready_o[E]=1, v_o[E]=0; a P flit to (3,1) is dropped, and ready_o[P] stays 1 after 4 such flits.

Source files
------------

// File: rtl/bsg_manycore_mesh_router.sv
// bsg_manycore_mesh_router
//   Five-port (P,W,E,N,S) dimension-ordered mesh switch. Every input port has
//   a small FIFO. Each output has its own round-robin arbiter over the FIFO
//   heads that route to it. Port index order is P=0, W=1, E=2, N=3, S=4.
//
// Ports
//   clk_i      clock
//   reset_i    synchronous reset, active low (0 = reset)
//   data_i     per-input flit {payload, y_cord, x_cord}, x_cord in the LSBs
//   v_i        per-input valid
//   ready_o    per-input FIFO not full (1 on stubbed ports, 0 during reset)
//   data_o     per-output flit (granted FIFO head, 0 when idle or stubbed)
//   v_o        per-output valid
//   ready_i    per-output downstream ready
//   my_x_i     local tile X coordinate
//   my_y_i     local tile Y coordinate
module bsg_manycore_mesh_router #(
  parameter int         x_cord_width_p  = 2,
  parameter int         y_cord_width_p  = 2,
  parameter int         data_width_p    = 32,
  parameter int         fifo_els_p      = 2,
  parameter logic [4:0] stub_p          = 5'b0,
  parameter bit         yx_order_p      = 1'b0,
  parameter int         packet_width_lp = data_width_p + x_cord_width_p + y_cord_width_p
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [4:0][packet_width_lp-1:0] data_i,
  input  logic [4:0]                      v_i,
  output logic [4:0]                      ready_o,
  output logic [4:0][packet_width_lp-1:0] data_o,
  output logic [4:0]                      v_o,
  input  logic [4:0]                      ready_i,
  input  logic [x_cord_width_p-1:0]       my_x_i,
  input  logic [y_cord_width_p-1:0]       my_y_i
);

  localparam int ptr_w_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int cnt_w_lp = $clog2(fifo_els_p + 1);

  localparam int dir_p_lp = 0;
  localparam int dir_w_lp = 1;
  localparam int dir_e_lp = 2;
  localparam int dir_n_lp = 3;
  localparam int dir_s_lp = 4;

  logic [packet_width_lp-1:0] mem_q [5][fifo_els_p];
  logic [ptr_w_lp-1:0]        rd_q  [5];
  logic [ptr_w_lp-1:0]        rd_d  [5];
  logic [ptr_w_lp-1:0]        wr_q  [5];
  logic [ptr_w_lp-1:0]        wr_d  [5];
  logic [cnt_w_lp-1:0]        cnt_q [5];
  logic [cnt_w_lp-1:0]        cnt_d [5];
  logic [2:0]                 arb_q [5];
  logic [2:0]                 arb_d [5];

  logic [4:0]                      full, empty, enq, deq;
  logic [4:0][packet_width_lp-1:0] head;
  logic [4:0][4:0]                 req;   // req[input][output]
  logic [4:0][2:0]                 gnt;
  logic [4:0]                      v_any, xfer;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(fifo_els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  // ready_o looks only at occupancy, so it never depends on v_i.
  always_comb begin : fifo_status
    for (int i = 0; i < 5; i++) begin
      full[i]    = (cnt_q[i] == cnt_w_lp'(fifo_els_p));
      empty[i]   = (cnt_q[i] == '0);
      head[i]    = mem_q[i][rd_q[i]];
      enq[i]     = v_i[i] & ~full[i] & ~stub_p[i];
      ready_o[i] = reset_i & (stub_p[i] | ~full[i]);
    end
  end

  always_comb begin : route
    logic [x_cord_width_p-1:0] dx;
    logic [y_cord_width_p-1:0] dy;
    logic x_lt, x_gt, y_lt, y_gt;
    for (int i = 0; i < 5; i++) begin
      req[i] = '0;
      dx     = head[i][x_cord_width_p-1:0];
      dy     = head[i][x_cord_width_p +: y_cord_width_p];
      x_lt   = (dx < my_x_i);
      x_gt   = (dx > my_x_i);
      y_lt   = (dy < my_y_i);
      y_gt   = (dy > my_y_i);
      if (!empty[i]) begin
        if (yx_order_p) begin
          if (y_lt)      req[i][dir_n_lp] = 1'b1;
          else if (y_gt) req[i][dir_s_lp] = 1'b1;
          else if (x_lt) req[i][dir_w_lp] = 1'b1;
          else if (x_gt) req[i][dir_e_lp] = 1'b1;
          else           req[i][dir_p_lp] = 1'b1;
        end else begin
          if (x_lt)      req[i][dir_w_lp] = 1'b1;
          else if (x_gt) req[i][dir_e_lp] = 1'b1;
          else if (y_lt) req[i][dir_n_lp] = 1'b1;
          else if (y_gt) req[i][dir_s_lp] = 1'b1;
          else           req[i][dir_p_lp] = 1'b1;
        end
      end
    end
  end

  // Scan starts at the pointer and wraps S->P. A stubbed output always
  // "accepts" so flits routed there are consumed and dropped.
  always_comb begin : arbitrate
    logic [3:0] sum;
    logic [2:0] idx;
    for (int o = 0; o < 5; o++) begin
      v_any[o] = 1'b0;
      gnt[o]   = arb_q[o];
      for (int k = 0; k < 5; k++) begin
        sum = {1'b0, arb_q[o]} + 4'(k);
        idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
        if (!v_any[o] && req[idx][o]) begin
          v_any[o] = 1'b1;
          gnt[o]   = idx;
        end
      end
      xfer[o]   = v_any[o] & (stub_p[o] | ready_i[o]);
      v_o[o]    = reset_i & v_any[o] & ~stub_p[o];
      data_o[o] = v_o[o] ? head[gnt[o]] : '0;
      arb_d[o]  = xfer[o] ? ((gnt[o] == 3'd4) ? 3'd0 : gnt[o] + 3'd1) : arb_q[o];
    end
  end

  always_comb begin : fifo_next
    for (int i = 0; i < 5; i++) begin
      deq[i] = 1'b0;
      for (int o = 0; o < 5; o++) begin
        if (xfer[o] && (gnt[o] == 3'(i))) deq[i] = 1'b1;
      end
      cnt_d[i] = cnt_q[i] + cnt_w_lp'(enq[i]) - cnt_w_lp'(deq[i]);
      wr_d[i]  = enq[i] ? ptr_inc(wr_q[i]) : wr_q[i];
      rd_d[i]  = deq[i] ? ptr_inc(rd_q[i]) : rd_q[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      for (int i = 0; i < 5; i++) begin
        cnt_q[i] <= '0;
        rd_q[i]  <= '0;
        wr_q[i]  <= '0;
        arb_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        cnt_q[i] <= cnt_d[i];
        rd_q[i]  <= rd_d[i];
        wr_q[i]  <= wr_d[i];
        arb_q[i] <= arb_d[i];
      end
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 5; i++) begin
      if (enq[i]) mem_q[i][wr_q[i]] <= data_i[i];
    end
  end

endmodule

// File: tb/tb_bsg_manycore_mesh_router.sv
module tb_bsg_manycore_mesh_router;
  localparam int XW = 2;
  localparam int YW = 2;
  localparam int DW = 32;
  localparam int PW = DW + XW + YW;
  localparam int ND = 3;

  // dut0: XY, dut1: YX, dut2: XY with E stubbed
  localparam logic [4:0] STUB [ND] = '{5'b00000, 5'b00000, 5'b00100};
  localparam bit         YX   [ND] = '{1'b0, 1'b1, 1'b0};

  localparam int XS [5] = '{0, 2, 1, 1, 1};
  localparam int YS [5] = '{2, 0, 0, 2, 1};
  localparam int DS [5] = '{1, 2, 3, 4, 0};

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic                   reset_i;
  logic [4:0][PW-1:0]     din  [ND];
  logic [4:0][PW-1:0]     dout [ND];
  logic [4:0]             vin  [ND];
  logic [4:0]             rdy_o[ND];
  logic [4:0]             vout [ND];
  logic [4:0]             rdy_i[ND];
  logic [4:0]             acc  [ND];
  logic [XW-1:0]          mx;
  logic [YW-1:0]          my;

  int checks = 0;
  int errors = 0;
  logic [PW-1:0] exp_q [ND*25][$];

  bsg_manycore_mesh_router #(.x_cord_width_p(XW), .y_cord_width_p(YW), .data_width_p(DW),
    .fifo_els_p(2), .stub_p(5'b00000), .yx_order_p(1'b0)) dut0 (
    .clk_i(clk_i), .reset_i(reset_i), .data_i(din[0]), .v_i(vin[0]), .ready_o(rdy_o[0]),
    .data_o(dout[0]), .v_o(vout[0]), .ready_i(rdy_i[0]), .my_x_i(mx), .my_y_i(my));

  bsg_manycore_mesh_router #(.x_cord_width_p(XW), .y_cord_width_p(YW), .data_width_p(DW),
    .fifo_els_p(2), .stub_p(5'b00000), .yx_order_p(1'b1)) dut1 (
    .clk_i(clk_i), .reset_i(reset_i), .data_i(din[1]), .v_i(vin[1]), .ready_o(rdy_o[1]),
    .data_o(dout[1]), .v_o(vout[1]), .ready_i(rdy_i[1]), .my_x_i(mx), .my_y_i(my));

  bsg_manycore_mesh_router #(.x_cord_width_p(XW), .y_cord_width_p(YW), .data_width_p(DW),
    .fifo_els_p(2), .stub_p(5'b00100), .yx_order_p(1'b0)) dut2 (
    .clk_i(clk_i), .reset_i(reset_i), .data_i(din[2]), .v_i(vin[2]), .ready_o(rdy_o[2]),
    .data_o(dout[2]), .v_o(vout[2]), .ready_i(rdy_i[2]), .my_x_i(mx), .my_y_i(my));

  // Flit: {src tag (3), payload (29), y, x}; the tag lets the monitor find the sender.
  function automatic logic [PW-1:0] mk(input int src, input int x, input int y, input int pl);
    return {3'(src), 29'(pl), 2'(y), 2'(x)};
  endfunction

  // Destination port from coordinate differences.
  function automatic int route(input int dx, input int dy, input int lx, input int ly, input bit yx);
    int ddx, ddy;
    ddx = dx - lx;
    ddy = dy - ly;
    if (yx) begin
      if (ddy < 0) return 3;
      if (ddy > 0) return 4;
      if (ddx < 0) return 1;
      if (ddx > 0) return 2;
    end else begin
      if (ddx < 0) return 1;
      if (ddx > 0) return 2;
      if (ddy < 0) return 3;
      if (ddy > 0) return 4;
    end
    return 0;
  endfunction

  function automatic int total_pending();
    int n = 0;
    for (int k = 0; k < ND*25; k++) n += exp_q[k].size();
    return n;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every transfer is popped against the (dut, src, dst) queue.
  always @(negedge clk_i) begin : monitor
    int src, key;
    logic [PW-1:0] e;
    if (reset_i) begin
      for (int d = 0; d < ND; d++) begin
        for (int o = 0; o < 5; o++) begin
          if (STUB[d][o]) begin
            check("stub_vo", 64'(vout[d][o]), 64'd0);
            check("stub_do", 64'(dout[d][o]), 64'd0);
          end
          if (vout[d][o] && rdy_i[d][o]) begin
            src = int'(dout[d][o][PW-1 -: 3]);
            key = d*25 + src*5 + o;
            if (src > 4 || exp_q[key].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL sb_unexpected: dut%0d out%0d got %0h expected none", d, o, dout[d][o]);
            end else begin
              e = exp_q[key].pop_front();
              check("sb_flit", 64'(dout[d][o]), 64'(e));
            end
          end
        end
      end
    end
  end

  // Record enqueues at mid-cycle, then advance to just after the next edge.
  task automatic step();
    int dst;
    @(negedge clk_i);
    for (int d = 0; d < ND; d++) begin
      acc[d] = vin[d] & rdy_o[d] & {5{reset_i}};
      for (int i = 0; i < 5; i++) begin
        if (acc[d][i] && !STUB[d][i]) begin
          dst = route(int'(din[d][i][1:0]), int'(din[d][i][3:2]), int'(mx), int'(my), YX[d]);
          if (!STUB[d][dst]) exp_q[d*25 + i*5 + dst].push_back(din[d][i]);
        end
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain(input int max_cycles);
    for (int d = 0; d < ND; d++) begin
      vin[d]   = '0;
      rdy_i[d] = '1;
    end
    for (int n = 0; n < max_cycles && total_pending() != 0; n++) step();
    check("drain_empty", 64'(total_pending()), 64'd0);
  endtask

  initial begin
    logic [PW-1:0] f0;
    logic [PW-1:0] seq [3];
    int accepted;

    reset_i = 1'b0;
    mx = 2'd1;
    my = 2'd1;
    for (int d = 0; d < ND; d++) begin
      rdy_i[d] = '1;
      vin[d]   = 5'b11111;
      acc[d]   = '0;
      for (int i = 0; i < 5; i++) din[d][i] = mk(i, 0, 0, 7);
    end

    // Reset held for 3 cycles with all inputs valid.
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_vo0", 64'(vout[0]), 64'd0);
      check("rst_rdy0", 64'(rdy_o[0]), 64'd0);
      check("rst_vo1", 64'(vout[1]), 64'd0);
      check("rst_rdy1", 64'(rdy_o[1]), 64'd0);
    end
    for (int d = 0; d < ND; d++) vin[d] = '0;
    reset_i = 1'b1;
    step();
    check("post_rst_rdy0", 64'(rdy_o[0]), 64'h1f);
    check("post_rst_vo0", 64'(vout[0]), 64'd0);
    check("post_rst_rdy2", 64'(rdy_o[2]), 64'h1f);

    // XY routing from P, one cycle latency.
    for (int k = 0; k < 5; k++) begin
      din[0][0] = mk(0, XS[k], YS[k], 100 + k);
      vin[0] = 5'b00001;
      step();
      vin[0] = '0;
      check("xy_vo", 64'(vout[0]), 64'(1) << DS[k]);
      check("xy_data", 64'(dout[0][DS[k]]), 64'(din[0][0]));
    end

    // YX order: Y resolved first.
    din[1][0] = mk(0, 2, 0, 200);
    vin[1] = 5'b00001;
    step();
    vin[1] = '0;
    check("yx_to_n", 64'(vout[1]), 64'b01000);
    din[1][0] = mk(0, 0, 2, 201);
    vin[1] = 5'b00001;
    step();
    vin[1] = '0;
    check("yx_to_s", 64'(vout[1]), 64'b10000);

    // Contention on output P: W, E, N all to (1,1).
    din[0][1] = mk(1, 1, 1, 'hA);
    din[0][2] = mk(2, 1, 1, 'hB);
    din[0][3] = mk(3, 1, 1, 'hC);
    seq = '{din[0][1], din[0][2], din[0][3]};
    vin[0] = 5'b01110;
    step();
    vin[0] = '0;
    for (int k = 0; k < 3; k++) begin
      check("rr1_v", 64'(vout[0][0]), 64'd1);
      check("rr1_order", 64'(dout[0][0]), 64'(seq[k]));
      step();
    end
    // W alone leaves the P-output pointer at E.
    din[0][1] = mk(1, 1, 1, 'h1A);
    vin[0] = 5'b00010;
    step();
    vin[0] = '0;
    check("rr_single", 64'(dout[0][0]), 64'(din[0][1]));
    step();
    din[0][1] = mk(1, 1, 1, 'h2A);
    din[0][2] = mk(2, 1, 1, 'h2B);
    din[0][3] = mk(3, 1, 1, 'h2C);
    seq = '{din[0][2], din[0][3], din[0][1]};
    vin[0] = 5'b01110;
    step();
    vin[0] = '0;
    for (int k = 0; k < 3; k++) begin
      check("rr2_order", 64'(dout[0][0]), 64'(seq[k]));
      step();
    end

    // Backpressure on E while P streams toward (3,1).
    rdy_i[0] = 5'b11011;
    accepted = 0;
    f0 = mk(0, 3, 1, 300);
    din[0][0] = f0;
    vin[0] = 5'b00001;
    for (int c = 0; c < 6; c++) begin
      step();
      if (acc[0][0]) begin
        accepted++;
        din[0][0] = mk(0, 3, 1, 300 + accepted);
      end
      check("bp_vo", 64'(vout[0][2]), 64'd1);
      check("bp_stable", 64'(dout[0][2]), 64'(f0));
    end
    check("bp_accepted", 64'(accepted), 64'd2);
    check("bp_rdy_low", 64'(rdy_o[0][0]), 64'd0);
    drain(20);

    // Stubbed E on dut2: flits toward E vanish; E input is ignored.
    check("stub_rdyE0", 64'(rdy_o[2][2]), 64'd1);
    for (int k = 0; k < 4; k++) begin
      din[2][0] = mk(0, 3, 1, 400 + k);
      din[2][2] = mk(2, 0, 1, 500 + k);
      vin[2] = 5'b00101;
      step();
      check("stub_rdyP", 64'(rdy_o[2][0]), 64'd1);
      check("stub_rdyE", 64'(rdy_o[2][2]), 64'd1);
    end
    drain(20);

    // Random traffic with random backpressure on all three instances.
    for (int c = 0; c < 800; c++) begin
      for (int d = 0; d < ND; d++) begin
        vin[d]   = 5'($urandom);
        rdy_i[d] = 5'($urandom) | 5'($urandom);
        for (int i = 0; i < 5; i++)
          din[d][i] = mk(i, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom));
      end
      step();
    end
    drain(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
